sram_mc_arbiter: RTL and testbench

Parametrised multi-channel controller for the asynchronous 48-bit board SRAM, arbitrating N_CH requesters (CPU data port, VRAM port, further DMA clients) onto one external SRAM bus. Adds round-robin arbitration, per-lane write masks with read-modify-write for partial writes, configurable read/write wait states, and a post-reset fill of a configurable SRAM region. Sits between the bus/VRAM masters and the SRAM pins at top level.

---
 rtl/sram_mc_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_sram_mc_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mc_arbiter.sv
// Round-robin multi-channel controller for the asynchronous board SRAM.
// Handles per-lane masked writes by read-modify-write, wait states and a post-reset region fill.
module sram_mc_arbiter #(
    parameter int                N_CH       = 2,
    parameter int                ADDR_W     = 20,
    parameter int                DATA_W     = 48,
    parameter int                LANE_W     = 16,
    parameter int                RD_CYCLES  = 2,
    parameter int                WR_CYCLES  = 2,
    parameter logic [ADDR_W-1:0] INIT_BASE  = 20'h80000,
    parameter int                INIT_WORDS = 128,
    parameter logic [DATA_W-1:0] INIT_VALUE = 48'h000008080000,
    localparam int               N_LANES    = DATA_W / LANE_W
) (
    input  logic                     clk_50mhz,
    input  logic                     rst,
    input  logic [N_CH-1:0]          ch_stb,
    input  logic [N_CH-1:0]          ch_we,
    input  logic [N_CH*ADDR_W-1:0]   ch_addr,
    input  logic [N_CH*DATA_W-1:0]   ch_din,
    input  logic [N_CH*N_LANES-1:0]  ch_mask,
    output logic [N_CH-1:0]          ch_ack,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     busy,
    output logic                     init_done,
    output logic [ADDR_W-1:0]        SRAM_ADDR,
    output logic                     SRAM_CE,
    output logic                     SRAM_OEN,
    output logic                     SRAM_WEN,
    inout  wire  [DATA_W-1:0]        SRAM_DQ
);

    localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [3:0] {
        S_INIT_SETUP, S_INIT_WR, S_INIT_HOLD, S_IDLE, S_RD,
        S_WR_SETUP, S_WR, S_WR_HOLD, S_DONE
    } state_t;

    localparam state_t RST_STATE = (INIT_WORDS == 0) ? S_IDLE : S_INIT_SETUP;

    state_t              r_state, w_next;
    logic [7:0]          r_cnt;
    logic [31:0]         r_init_cnt;
    logic [ADDR_W-1:0]   r_init_addr, r_addr, w_addr;
    logic [GW-1:0]       r_grant, r_last, w_sel, w_try;
    logic [DATA_W-1:0]   r_din, r_old, r_rd_data, w_wdata, w_dq_out;
    logic [N_LANES-1:0]  r_mask, w_req_mask;
    logic                r_partial, r_init_done;
    logic                w_req, w_req_we, w_fill_last, w_rd_last, w_wr_last;
    logic                w_ce, w_oen, w_wen, w_dq_oe;

    assign w_rd_last   = (r_cnt == 8'(RD_CYCLES - 1));
    assign w_wr_last   = (r_cnt == 8'(WR_CYCLES - 1));
    assign w_fill_last = (r_init_cnt == 32'(INIT_WORDS - 1));

    // Walk downwards so the last hit is the nearest channel after r_last.
    always_comb begin
        w_req = 1'b0;
        w_sel = r_last;
        w_try = '0;
        for (int k = N_CH; k >= 1; k--) begin
            w_try = GW'((int'(r_last) + k) % N_CH);
            if (ch_stb[w_try]) begin
                w_req = 1'b1;
                w_sel = w_try;
            end
        end
    end

    assign w_req_we   = ch_we[w_sel];
    assign w_req_mask = ch_mask[int'(w_sel)*N_LANES +: N_LANES];

    always_comb begin
        w_wdata = r_old;
        for (int l = 0; l < N_LANES; l++) begin
            if (r_mask[l])
                w_wdata[l*LANE_W +: LANE_W] = r_din[l*LANE_W +: LANE_W];
        end
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) r_state <= RST_STATE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT_SETUP: w_next = S_INIT_WR;
            S_INIT_WR:    if (w_wr_last) w_next = S_INIT_HOLD;
            S_INIT_HOLD:  w_next = w_fill_last ? S_IDLE : S_INIT_SETUP;
            S_IDLE:       if (w_req) w_next = (w_req_we && (&w_req_mask)) ? S_WR_SETUP : S_RD;
            S_RD:         if (w_rd_last) w_next = r_partial ? S_WR_SETUP : S_DONE;
            S_WR_SETUP:   w_next = S_WR;
            S_WR:         if (w_wr_last) w_next = S_WR_HOLD;
            S_WR_HOLD:    w_next = S_DONE;
            S_DONE:       w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    // Pin controls decode straight from state and are forced inactive by rst without a clock.
    always_comb begin
        w_ce     = 1'b1;
        w_oen    = 1'b1;
        w_wen    = 1'b1;
        w_dq_oe  = 1'b0;
        w_addr   = r_addr;
        w_dq_out = w_wdata;
        if (rst) begin
            w_addr = '0;
        end else begin
            case (r_state)
                S_INIT_SETUP, S_INIT_HOLD: begin
                    w_ce = 1'b0; w_dq_oe = 1'b1; w_addr = r_init_addr; w_dq_out = INIT_VALUE;
                end
                S_INIT_WR: begin
                    w_ce = 1'b0; w_wen = 1'b0; w_dq_oe = 1'b1; w_addr = r_init_addr; w_dq_out = INIT_VALUE;
                end
                S_RD:                  begin w_ce = 1'b0; w_oen = 1'b0; end
                S_WR_SETUP, S_WR_HOLD: begin w_ce = 1'b0; w_dq_oe = 1'b1; end
                S_WR:                  begin w_ce = 1'b0; w_wen = 1'b0; w_dq_oe = 1'b1; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_init_cnt  <= '0;
            r_init_addr <= INIT_BASE;
            r_init_done <= (INIT_WORDS == 0);
            r_grant     <= '0;
            r_last      <= GW'(N_CH - 1);
            r_addr      <= '0;
            r_din       <= '0;
            r_mask      <= '0;
            r_partial   <= 1'b0;
            r_old       <= '0;
            r_rd_data   <= '0;
        end else begin
            r_cnt <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
            case (r_state)
                S_INIT_HOLD: begin
                    r_init_addr <= r_init_addr + 1'b1;
                    r_init_cnt  <= r_init_cnt + 32'd1;
                    if (w_fill_last) r_init_done <= 1'b1;
                end
                S_IDLE: if (w_req) begin
                    r_grant   <= w_sel;
                    r_last    <= w_sel;
                    r_addr    <= ch_addr[int'(w_sel)*ADDR_W +: ADDR_W];
                    r_din     <= ch_din[int'(w_sel)*DATA_W +: DATA_W];
                    r_mask    <= w_req_mask;
                    r_partial <= w_req_we && (|w_req_mask) && !(&w_req_mask);
                end
                S_RD: if (w_rd_last) begin
                    r_old <= SRAM_DQ;
                    if (!r_partial) r_rd_data <= SRAM_DQ;
                end
                // Partial writes report the pre-merge word, full writes the written word.
                S_WR_HOLD: r_rd_data <= r_partial ? r_old : r_din;
                default: ;
            endcase
        end
    end

    assign SRAM_CE   = w_ce;
    assign SRAM_OEN  = w_oen;
    assign SRAM_WEN  = w_wen;
    assign SRAM_ADDR = w_addr;
    assign SRAM_DQ   = w_dq_oe ? w_dq_out : {DATA_W{1'bz}};

    assign ch_ack    = (r_state == S_DONE) ? (N_CH'(1) << r_grant) : '0;
    assign rd_data   = r_rd_data;
    assign busy      = (r_state != S_IDLE);
    assign init_done = r_init_done;

endmodule

// File: tb/tb_sram_mc_arbiter.sv
// Bench for sram_mc_arbiter: SRAM pin model, directed vector table, round-robin and reset
// sequences, plus random traffic checked against an array-based reference memory.
module tb_sram_mc_arbiter;
    localparam int RDC = 2, WRC = 2;
    localparam logic [47:0] INIT_V = 48'h000008080000;

    logic        clk_50mhz = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  ch_stb = '0, ch_we = '0;
    logic [39:0] ch_addr = '0;
    logic [95:0] ch_din = '0;
    logic [5:0]  ch_mask = '0;
    logic [1:0]  ch_ack;
    logic [47:0] rd_data;
    logic        busy, init_done;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE, SRAM_OEN, SRAM_WEN;
    wire  [47:0] SRAM_DQ;

    sram_mc_arbiter dut (
        .clk_50mhz(clk_50mhz), .rst(rst), .ch_stb(ch_stb), .ch_we(ch_we),
        .ch_addr(ch_addr), .ch_din(ch_din), .ch_mask(ch_mask), .ch_ack(ch_ack),
        .rd_data(rd_data), .busy(busy), .init_done(init_done), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_CE(SRAM_CE), .SRAM_OEN(SRAM_OEN), .SRAM_WEN(SRAM_WEN), .SRAM_DQ(SRAM_DQ)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    // SRAM pin model and protocol monitors
    logic [47:0] mem [0:(1<<20)-1];
    logic [47:0] sram_q;
    logic        pre_en = 1'b0, tb_force = 1'b0;
    logic [19:0] pre_addr = '0;
    logic [47:0] pre_val = '0;
    int          both_low, addr_chg, wen_low, both_ack, fill_ack;
    logic        prev_wen;
    logic [19:0] prev_addr;

    assign SRAM_DQ = (!SRAM_CE && !SRAM_OEN) ? sram_q : (tb_force ? 48'h0 : 48'hz);

    always @(negedge clk_50mhz) begin
        if (pre_en) mem[pre_addr] <= pre_val;
        else if (!SRAM_CE && !SRAM_WEN) mem[SRAM_ADDR] <= SRAM_DQ;
        sram_q <= mem[SRAM_ADDR];
        if (rst) begin
            both_low <= 0; addr_chg <= 0; wen_low <= 0; both_ack <= 0; fill_ack <= 0;
        end else begin
            if (!SRAM_OEN && !SRAM_WEN) both_low <= both_low + 1;
            if (!SRAM_WEN && !prev_wen && SRAM_ADDR != prev_addr) addr_chg <= addr_chg + 1;
            if (!SRAM_WEN) wen_low <= wen_low + 1;
            if (&ch_ack) both_ack <= both_ack + 1;
            if (!init_done && |ch_ack) fill_ack <= fill_ack + 1;
        end
        prev_wen  <= SRAM_WEN;
        prev_addr <= SRAM_ADDR;
    end

    int checks = 0, errors = 0;
    int last_ch = 1;
    logic [47:0] ref_mem [int];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [19:0] a, input logic [47:0] v);
        pre_addr = a; pre_val = v; pre_en = 1'b1;
        @(negedge clk_50mhz); #1;
        pre_en = 1'b0;
        @(posedge clk_50mhz); #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000 && busy; i++) begin
            @(posedge clk_50mhz); #1;
        end
    endtask

    task automatic do_txn(input int ch, input bit we, input logic [19:0] a, input logic [47:0] d,
                          input logic [2:0] m, output int lat, output logic [47:0] rd);
        wait_idle();
        ch_we[ch] = we; ch_addr[ch*20 +: 20] = a; ch_din[ch*48 +: 48] = d; ch_mask[ch*3 +: 3] = m;
        ch_stb[ch] = 1'b1;
        lat = -1; rd = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk_50mhz); #1;
            if (ch_ack[ch]) begin lat = n; rd = rd_data; break; end
        end
        ch_stb[ch] = 1'b0;
        last_ch = ch;
    endtask

    // Expected latency and results from the timing and lane-merge rules.
    function automatic int exp_lat(input bit we, input logic [2:0] m);
        if (!we || m == 3'b000) return RDC + 1;
        if (m == 3'b111)        return WRC + 3;
        return RDC + WRC + 3;
    endfunction

    function automatic logic [47:0] merge(input logic [47:0] old, input logic [47:0] d, input logic [2:0] m);
        logic [47:0] r;
        r = old;
        if (m[0]) r[15:0]  = d[15:0];
        if (m[1]) r[31:16] = d[31:16];
        if (m[2]) r[47:32] = d[47:32];
        return r;
    endfunction

    typedef struct {
        int          ch;
        bit          we;
        logic [19:0] addr;
        logic [47:0] din;
        logic [2:0]  mask;
        bit          pre;
        logic [47:0] pre_val;
        int          lat;
        logic [47:0] rd;
        logic [47:0] mem;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int lat, n, done_at, bad, got, nacks, prev_n;
        logic [47:0] rd, exp_rd, v;
        bit we, found;
        logic [2:0] m;
        logic [19:0] a;
        int ch;

        tbl[0] = '{0, 1'b1, 20'h10, 48'h123456789ABC, 3'b111, 1'b0, 48'h0, 5, 48'h123456789ABC, 48'h123456789ABC};
        tbl[1] = '{0, 1'b0, 20'h10, 48'h0,            3'b000, 1'b0, 48'h0, 3, 48'h123456789ABC, 48'h123456789ABC};
        tbl[2] = '{1, 1'b1, 20'h10, 48'h111122223333, 3'b100, 1'b1, 48'hAAAABBBBCCCC, 7, 48'hAAAABBBBCCCC, 48'h1111BBBBCCCC};
        tbl[3] = '{1, 1'b1, 20'h10, 48'hFFFFFFFFFFFF, 3'b000, 1'b0, 48'h0, 3, 48'h1111BBBBCCCC, 48'h1111BBBBCCCC};
        tbl[4] = '{0, 1'b1, 20'h20, 48'hFFFFEEEEDDDD, 3'b011, 1'b1, 48'h0123456789AB, 7, 48'h0123456789AB, 48'h0123EEEEDDDD};
        tbl[5] = '{1, 1'b1, 20'h21, 48'hABCD12345678, 3'b101, 1'b1, 48'h0, 7, 48'h0, 48'hABCD00005678};

        // Sentinels just outside the fill region, written while reset is held.
        preload(20'h80080, 48'hDEADBEEF0001);
        preload(20'h7FFFF, 48'hDEADBEEF0002);
        chk("rst_ack", 64'(ch_ack), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_ce_oen_wen", 64'({SRAM_CE, SRAM_OEN, SRAM_WEN}), 64'b111);
        chk("rst_addr", 64'(SRAM_ADDR), 64'd0);

        // A read held pending across the whole fill.
        ch_we[0] = 1'b0; ch_addr[19:0] = 20'h80005; ch_stb[0] = 1'b1;
        rst = 1'b0;
        done_at = -1; n = 0;
        for (int i = 1; i <= 700; i++) begin
            @(posedge clk_50mhz); #1;
            n = i;
            if (init_done && done_at < 0) done_at = i;
            if (ch_ack[0]) break;
        end
        chk("fill_cycles", 64'(done_at), 64'd512);
        chk("first_ack_cycle", 64'(n), 64'd515);
        chk("first_rd_data", 64'(rd_data), 64'(INIT_V));
        ch_stb[0] = 1'b0; last_ch = 0;
        chk("no_ack_in_fill", 64'(fill_ack), 64'd0);
        bad = 0;
        for (int i = 0; i < 128; i++) if (mem[20'h80000 + 20'(i)] !== INIT_V) bad++;
        chk("fill_words", 64'(bad), 64'd0);
        chk("fill_above", 64'(mem[20'h80080]), 64'h0000DEADBEEF0001);
        chk("fill_below", 64'(mem[20'h7FFFF]), 64'h0000DEADBEEF0002);

        foreach (tbl[i]) begin
            int w0;
            if (tbl[i].pre) preload(tbl[i].addr, tbl[i].pre_val);
            w0 = wen_low;
            do_txn(tbl[i].ch, tbl[i].we, tbl[i].addr, tbl[i].din, tbl[i].mask, lat, rd);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
            chk($sformatf("vec%0d_rd", i), 64'(rd), 64'(tbl[i].rd));
            chk($sformatf("vec%0d_mem", i), 64'(mem[tbl[i].addr]), 64'(tbl[i].mem));
            if (tbl[i].we && tbl[i].mask == 3'b000) chk($sformatf("vec%0d_no_wen", i), 64'(wen_low - w0), 64'd0);
        end

        // Both channels requesting reads continuously: strict alternation, 4-cycle period.
        wait_idle();
        ch_we = 2'b00; ch_addr[19:0] = 20'h10; ch_addr[39:20] = 20'h20; ch_stb = 2'b11;
        nacks = 0; prev_n = 0;
        for (int i = 1; i <= 60 && nacks < 6; i++) begin
            @(posedge clk_50mhz); #1;
            if (|ch_ack) begin
                got = ch_ack[1] ? 1 : 0;
                ch = (last_ch + 1) % 2;
                exp_rd = (ch == 0) ? 48'h1111BBBBCCCC : 48'h0123EEEEDDDD;
                chk($sformatf("rr%0d_grant", nacks), 64'(got), 64'(ch));
                chk($sformatf("rr%0d_rd", nacks), 64'(rd_data), 64'(exp_rd));
                chk($sformatf("rr%0d_period", nacks), 64'(i - prev_n), (nacks == 0) ? 64'd3 : 64'd4);
                prev_n = i; last_ch = ch; nacks++;
            end
        end
        ch_stb = 2'b00;
        chk("rr_ack_count", 64'(nacks), 64'd6);

        // Random traffic against the reference memory.
        for (int i = 0; i < 16; i++) begin
            v = {16'($urandom), $urandom};
            ref_mem[i] = v;
            preload(20'h100 + 20'(i), v);
        end
        for (int t = 0; t < 40; t++) begin
            ch = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            m  = 3'($urandom_range(0, 7));
            a  = 20'($urandom_range(0, 15));
            v  = {16'($urandom), $urandom};
            exp_rd = ref_mem[int'(a)];
            if (we && m == 3'b111) exp_rd = v;
            do_txn(ch, we, 20'h100 + a, v, m, lat, rd);
            chk($sformatf("rnd%0d_lat", t), 64'(lat), 64'(exp_lat(we, m)));
            chk($sformatf("rnd%0d_rd", t), 64'(rd), 64'(exp_rd));
            if (we) ref_mem[int'(a)] = merge(ref_mem[int'(a)], v, m);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[20'h100 + 20'(i)] !== ref_mem[i]) bad++;
        chk("rnd_mem", 64'(bad), 64'd0);
        chk("oen_wen_overlap", 64'(both_low), 64'd0);
        chk("addr_change_under_wen", 64'(addr_chg), 64'd0);
        chk("ack_not_onehot", 64'(both_ack), 64'd0);

        // Asynchronous reset in the middle of a write pulse.
        wait_idle();
        ch_we[0] = 1'b1; ch_addr[19:0] = 20'h30; ch_din[47:0] = 48'hCAFEF00D1234; ch_mask[2:0] = 3'b111;
        ch_stb[0] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk_50mhz); #1;
            if (!SRAM_WEN) found = 1'b1;
        end
        chk("midwr_found_wen", 64'(found), 64'd1);
        #2 rst = 1'b1; tb_force = 1'b1;
        #1;
        chk("midwr_pins_idle", 64'({SRAM_CE, SRAM_OEN, SRAM_WEN}), 64'b111);
        chk("midwr_dq_released", 64'(SRAM_DQ), 64'd0);
        chk("midwr_ack", 64'(ch_ack), 64'd0);
        chk("midwr_init_done", 64'(init_done), 64'd0);
        ch_stb = 2'b00; tb_force = 1'b0;
        @(posedge clk_50mhz); #1;
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk_50mhz); #1;
            if (!SRAM_WEN) found = 1'b1;
        end
        chk("refill_first_addr", 64'(SRAM_ADDR), 64'h80000);
        for (int i = 0; i < 600 && !init_done; i++) begin
            @(posedge clk_50mhz); #1;
        end
        chk("refill_done", 64'(init_done), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
